// File: rtl/saturn_jump_operand_collector_if.sv
// rtl/saturn_jump_operand_collector_if.sv - decoder/fetch-side signal bundle for the jump operand collector
interface saturn_jump_operand_collector_if #(
    parameter int ADDR_W      = 20,
    parameter int MAX_NIBBLES = 5,
    parameter int LEN_W       = 3
);
    logic                     i_clk_en;
    logic [3:0]               i_phases;
    logic                     i_bus_busy;
    logic                     i_start;
    logic [LEN_W-1:0]         i_length;
    logic                     i_relative;
    logic                     i_push_pc;
    logic [ADDR_W-1:0]        i_base_pc;
    logic [3:0]               i_nibble;
    logic                     o_busy;
    logic                     o_done;
    logic [ADDR_W-1:0]        o_target;
    logic [MAX_NIBBLES*4-1:0] o_offset;
    logic                     o_push_pc;
    logic                     o_length_error;
    logic                     o_rtn;

    modport master (
        output i_clk_en, i_phases, i_bus_busy, i_start, i_length, i_relative,
               i_push_pc, i_base_pc, i_nibble,
        input  o_busy, o_done, o_target, o_offset, o_push_pc, o_length_error, o_rtn
    );

    modport slave (
        input  i_clk_en, i_phases, i_bus_busy, i_start, i_length, i_relative,
               i_push_pc, i_base_pc, i_nibble,
        output o_busy, o_done, o_target, o_offset, o_push_pc, o_length_error, o_rtn
    );
endinterface

// File: rtl/saturn_jump_operand_collector.sv
// rtl/saturn_jump_operand_collector.sv - variable-length jump operand collector; SATURN_JUMP_RTNYES_EN enables GOYES 00 return detection
module saturn_jump_operand_collector #(
    parameter int ADDR_W      = 20,
    parameter int MAX_NIBBLES = 5,
    parameter int LEN_W       = 3
) (
    input logic i_clk,
    input logic i_reset,
    saturn_jump_operand_collector_if.slave bus
);
    localparam int OFF_W = MAX_NIBBLES * 4;
    localparam int WIDE  = (OFF_W > ADDR_W) ? OFF_W : ADDR_W;

    typedef enum logic [1:0] {IDLE, COLLECT, CALC} state_t;

    state_t            state, state_next;
    logic [LEN_W-1:0]  len_q, cnt;
    logic              rel_q, push_q;
    logic [ADDR_W-1:0] base_q;
    logic [OFF_W-1:0]  offset, off_next;
    logic [WIDE-1:0]   off_wide;
    logic [ADDR_W-1:0] target, target_next, ext;
    logic              done, busy, push_out, len_err, sign;
    logic              len_ok, accept, reject, take, last;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        take       = 1'b0;
        last       = 1'b0;
        len_ok     = (bus.i_length != '0) && (int'(bus.i_length) <= MAX_NIBBLES);
        case (state)
            IDLE: begin
                if (bus.i_clk_en && bus.i_start) begin
                    if (len_ok) begin
                        accept     = 1'b1;
                        state_next = COLLECT;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bus.i_clk_en && bus.i_phases[2] && !bus.i_bus_busy) begin
                    take = 1'b1;
                    if (cnt == len_q - LEN_W'(1)) begin
                        last       = 1'b1;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.i_clk_en) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Target is computed from the offset including the nibble being captured,
    // so o_done lands exactly one enabled clock after the last sample.
    always_comb begin
        off_next = offset;
        for (int n = 0; n < MAX_NIBBLES; n++) begin
            if (int'(cnt) == n) off_next[4*n +: 4] = bus.i_nibble;
        end
        off_wide = WIDE'(off_next);
        sign     = 1'b0;
        for (int n = 0; n < MAX_NIBBLES; n++) begin
            if (int'(len_q) == n + 1) sign = off_next[4*n+3];
        end
        ext = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (i < 4 * int'(len_q)) ext[i] = off_wide[i];
            else                     ext[i] = rel_q & sign;
        end
        target_next = rel_q ? (base_q + ext) : ext;
    end

`ifdef SATURN_JUMP_RTNYES_EN
    logic rtn, rtn_next;

    always_comb begin
        rtn_next = rel_q && (len_q == LEN_W'(2)) && (ext[7:0] == 8'h00);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)                           rtn <= 1'b0;
        else if (last)                         rtn <= rtn_next;
        else if (state == CALC && bus.i_clk_en) rtn <= 1'b0;
    end

    assign bus.o_rtn = rtn;
`else
    logic rtn_next;
    assign rtn_next  = 1'b0;
    assign bus.o_rtn = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            len_q    <= '0;
            cnt      <= '0;
            rel_q    <= 1'b0;
            push_q   <= 1'b0;
            base_q   <= '0;
            offset   <= '0;
            target   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            push_out <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            if (reject) len_err <= 1'b1;
            if (accept) begin
                len_q  <= bus.i_length;
                rel_q  <= bus.i_relative;
                push_q <= bus.i_push_pc;
                base_q <= bus.i_base_pc;
                offset <= '0;
                cnt    <= '0;
                busy   <= 1'b1;
            end
            if (take) begin
                offset <= off_next;
                cnt    <= cnt + LEN_W'(1);
            end
            if (last) begin
                target   <= rtn_next ? '0 : target_next;
                done     <= 1'b1;
                busy     <= 1'b0;
                push_out <= push_q;
            end
            if (state == CALC && bus.i_clk_en) done <= 1'b0;
        end
    end

    assign bus.o_busy         = busy;
    assign bus.o_done         = done;
    assign bus.o_target       = target;
    assign bus.o_offset       = offset;
    assign bus.o_push_pc      = push_out;
    assign bus.o_length_error = len_err;
endmodule

// File: tb/tb_saturn_jump_operand_collector.sv
// tb/tb_saturn_jump_operand_collector.sv - randomized self-checking bench for saturn_jump_operand_collector
module tb_saturn_jump_operand_collector;
    localparam int ADDR_W = 20, MAX_NIBBLES = 5, LEN_W = 3, OFF_W = 20;

    logic clk = 1'b0;
    logic reset;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    saturn_jump_operand_collector_if #(.ADDR_W(ADDR_W), .MAX_NIBBLES(MAX_NIBBLES), .LEN_W(LEN_W)) bus();

    saturn_jump_operand_collector #(.ADDR_W(ADDR_W), .MAX_NIBBLES(MAX_NIBBLES), .LEN_W(LEN_W)) dut (
        .i_clk(clk), .i_reset(reset), .bus(bus)
    );

    typedef struct packed {
        logic busy_start, busy_mid, done, done_hold, done_fall, busy_end, push, rtn, rtn_fall;
        logic [ADDR_W-1:0] target, target_later;
        logic [OFF_W-1:0]  offset;
    } obs_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: offset value interpreted as a (4*len)-bit two's complement number when relative.
    function automatic logic [ADDR_W-1:0] model_target(int len, bit rel, logic [ADDR_W-1:0] base, longint val);
        longint s;
`ifdef SATURN_JUMP_RTNYES_EN
        if (rel && len == 2 && val == 0) return '0;
`endif
        s = val;
        if (rel && ((val >> (4*len-1)) & 1) != 0) s = val - (longint'(1) << (4*len));
        if (rel) s = s + longint'(base);
        return s[ADDR_W-1:0];
    endfunction

    task automatic run_jump(input int len, input bit rel, input bit push, input logic [ADDR_W-1:0] base,
                            input longint val, input int stall_slot, input bit jitter, input bit restart,
                            output obs_t o);
        o = '0;
        bus.i_start = 1'b1; bus.i_length = LEN_W'(len); bus.i_relative = rel;
        bus.i_push_pc = push; bus.i_base_pc = base;
        tick();
        bus.i_start = 1'b0;
        o.busy_start = bus.o_busy;
        for (int k = 0; k < len; k++) begin
            if (jitter) begin
                repeat ($urandom_range(0, 2)) begin
                    if ($urandom_range(0, 1) == 1) begin
                        bus.i_clk_en = 1'b0; bus.i_phases = 4'b0100;
                    end else begin
                        bus.i_phases = ($urandom_range(0, 1) == 1) ? 4'b0010 : 4'b1000;
                    end
                    bus.i_nibble = 4'($urandom);
                    tick();
                    bus.i_clk_en = 1'b1;
                end
            end
            if (k == stall_slot) begin
                bus.i_phases = 4'b0100; bus.i_bus_busy = 1'b1;
                bus.i_nibble = ~4'((val >> (4*k)) & 15);
                tick();
                bus.i_bus_busy = 1'b0;
            end
            bus.i_phases = 4'b0100;
            bus.i_nibble = 4'((val >> (4*k)) & 15);
            if (restart && k == 0) begin
                bus.i_start = 1'b1; bus.i_length = LEN_W'(1); bus.i_relative = ~rel;
                bus.i_push_pc = ~push; bus.i_base_pc = ~base;
            end
            tick();
            bus.i_start = 1'b0; bus.i_phases = 4'b0001;
            if (k == 0) o.busy_mid = bus.o_busy;
        end
        o.done = bus.o_done; o.target = bus.o_target; o.offset = bus.o_offset;
        o.push = bus.o_push_pc; o.rtn = bus.o_rtn; o.busy_end = bus.o_busy;
        bus.i_clk_en = 1'b0; bus.i_phases = 4'b0100;
        tick();
        o.done_hold = bus.o_done;
        bus.i_clk_en = 1'b1; bus.i_phases = 4'b0001;
        tick();
        o.done_fall = bus.o_done; o.rtn_fall = bus.o_rtn;
        repeat (2) tick();
        o.target_later = bus.o_target;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.i_clk_en = 1'b1; bus.i_phases = 4'b0100; bus.i_bus_busy = 1'b0; bus.i_start = 1'b1;
        bus.i_length = 3'd3; bus.i_relative = 1'b1; bus.i_push_pc = 1'b1; bus.i_base_pc = 20'h12345;
        bus.i_nibble = 4'hF;
        repeat (3) tick();
        checks++;
        if ({bus.o_busy, bus.o_done, bus.o_target, bus.o_offset, bus.o_push_pc, bus.o_length_error, bus.o_rtn} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b target=%h offset=%h push=%b err=%b rtn=%b, all required 0",
                     bus.o_busy, bus.o_done, bus.o_target, bus.o_offset, bus.o_push_pc, bus.o_length_error, bus.o_rtn);
        end
        bus.i_start = 1'b0; bus.i_phases = 4'b0001; bus.i_push_pc = 1'b0; bus.i_relative = 1'b0;
        reset = 1'b0;
        tick();
        checks++;
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b required 0", bus.o_busy); end
    endtask

    task automatic test_relative();
        obs_t o;
        run_jump(3, 1'b1, 1'b0, 20'h00100, 64'h234, -1, 1'b0, 1'b0, o);
        checks++; if (o.done !== 1'b1) begin errors++; $display("FAIL rel_done: got %b required 1", o.done); end
        checks++; if (o.target !== 20'h00334) begin errors++; $display("FAIL rel_target: got %h required 00334", o.target); end
        checks++; if (o.offset !== 20'h00234) begin errors++; $display("FAIL rel_offset: got %h required 00234", o.offset); end
        checks++; if (o.push !== 1'b0) begin errors++; $display("FAIL rel_push: got %b required 0", o.push); end
        checks++; if ({o.busy_start, o.busy_mid, o.busy_end} !== 3'b110) begin errors++; $display("FAIL rel_busy: got %b required 110", {o.busy_start, o.busy_mid, o.busy_end}); end
        checks++; if ({o.done_hold, o.done_fall} !== 2'b10) begin errors++; $display("FAIL rel_done_pulse: hold/fall got %b required 10", {o.done_hold, o.done_fall}); end
    endtask

    task automatic test_wrap();
        obs_t o;
        run_jump(4, 1'b1, 1'b1, 20'h00200, 64'hF000, -1, 1'b0, 1'b0, o);
        checks++; if (o.target !== 20'hFF200) begin errors++; $display("FAIL wrap_target: got %h required ff200", o.target); end
        checks++; if (o.push !== 1'b1) begin errors++; $display("FAIL wrap_push: got %b required 1", o.push); end
    endtask

    task automatic test_stall();
        obs_t o;
        run_jump(5, 1'b0, 1'b0, 20'hABCDE, 64'h12345, 1, 1'b0, 1'b0, o);
        checks++; if (o.target !== 20'h12345) begin errors++; $display("FAIL stall_target: got %h required 12345", o.target); end
        checks++; if ({o.done, o.done_fall} !== 2'b10) begin errors++; $display("FAIL stall_done: got %b required 10", {o.done, o.done_fall}); end
    endtask

    task automatic test_length_error();
        obs_t o;
        int bad[3] = '{0, 6, 7};
        for (int i = 0; i < 3; i++) begin
            bus.i_start = 1'b1; bus.i_length = LEN_W'(bad[i]); bus.i_relative = 1'b0; bus.i_base_pc = '0;
            tick();
            bus.i_start = 1'b0;
            checks++;
            if ({bus.o_length_error, bus.o_busy, bus.o_done} !== 3'b100) begin
                errors++;
                $display("FAIL len_err_%0d: err/busy/done got %b required 100", bad[i], {bus.o_length_error, bus.o_busy, bus.o_done});
            end
            tick();
            checks++;
            if (bus.o_target !== 20'h12345) begin errors++; $display("FAIL len_err_hold_%0d: target got %h required 12345", bad[i], bus.o_target); end
        end
        run_jump(2, 1'b0, 1'b1, 20'h0, 64'h5A, -1, 1'b0, 1'b0, o);
        checks++; if ({o.done, o.target} !== {1'b1, 20'h0005A}) begin errors++; $display("FAIL len_err_recover: done/target got %b/%h required 1/0005a", o.done, o.target); end
        checks++; if (bus.o_length_error !== 1'b1) begin errors++; $display("FAIL len_err_sticky: got %b required 1", bus.o_length_error); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bus.i_start = 1'b1; bus.i_length = 3'd5; bus.i_relative = 1'b1; bus.i_push_pc = 1'b1; bus.i_base_pc = 20'h11111;
        tick();
        bus.i_start = 1'b0; bus.i_phases = 4'b0100; bus.i_nibble = 4'h7;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; bus.i_phases = 4'b0001;
        checks++;
        if ({bus.o_busy, bus.o_done, bus.o_target, bus.o_offset, bus.o_push_pc, bus.o_length_error, bus.o_rtn} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b target=%h offset=%h err=%b, all required 0", bus.o_busy, bus.o_target, bus.o_offset, bus.o_length_error);
        end
        run_jump(2, 1'b0, 1'b0, 20'h0, 64'hBA, -1, 1'b0, 1'b0, o);
        checks++; if (o.target !== 20'h000BA) begin errors++; $display("FAIL reset_mid_next: target got %h required 000ba", o.target); end
    endtask

    task automatic test_rtnyes();
        obs_t o;
        logic [ADDR_W-1:0] exp_t;
        logic exp_r;
`ifdef SATURN_JUMP_RTNYES_EN
        exp_t = 20'h0; exp_r = 1'b1;
`else
        exp_t = 20'h00400; exp_r = 1'b0;
`endif
        run_jump(2, 1'b1, 1'b0, 20'h00400, 64'h00, -1, 1'b0, 1'b0, o);
        checks++; if ({o.done, o.rtn, o.target} !== {1'b1, exp_r, exp_t}) begin errors++; $display("FAIL rtnyes: done/rtn/target got %b/%b/%h required 1/%b/%h", o.done, o.rtn, o.target, exp_r, exp_t); end
        checks++; if (o.rtn_fall !== 1'b0) begin errors++; $display("FAIL rtnyes_clear: rtn got %b required 0", o.rtn_fall); end
    endtask

    task automatic test_random();
        obs_t o;
        for (int it = 0; it < 60; it++) begin
            int len = $urandom_range(1, MAX_NIBBLES);
            bit rel = 1'($urandom);
            bit push = 1'($urandom);
            logic [ADDR_W-1:0] base = ADDR_W'($urandom);
            longint val = longint'($urandom) & ((longint'(1) << (4*len)) - 1);
            int stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len-1)) : -1;
            logic [ADDR_W-1:0] exp_t;
            if ($urandom_range(0, 7) == 0) val = 0;
            exp_t = model_target(len, rel, base, val);
            run_jump(len, rel, push, base, val, stall, 1'b1, 1'($urandom), o);
            checks++;
            if ({o.done, o.target, o.push, o.offset} !== {1'b1, exp_t, push, OFF_W'(val)}) begin
                errors++;
                $display("FAIL random_%0d: done/target/push/offset got %b/%h/%b/%h required 1/%h/%b/%h (len=%0d rel=%b base=%h)",
                         it, o.done, o.target, o.push, o.offset, exp_t, push, OFF_W'(val), len, rel, base);
            end
            checks++;
            if ({o.busy_start, o.busy_mid, o.busy_end, o.done_hold, o.done_fall, o.target_later} !== {1'b1, (len > 1), 1'b0, 1'b1, 1'b0, exp_t}) begin
                errors++;
                $display("FAIL random_ctl_%0d: busy s/m/e=%b%b%b done hold/fall=%b%b target_later=%h (len=%0d)",
                         it, o.busy_start, o.busy_mid, o.busy_end, o.done_hold, o.done_fall, o.target_later, len);
            end
        end
        checks++;
        if (bus.o_length_error !== 1'b0) begin errors++; $display("FAIL random_no_len_err: got %b required 0", bus.o_length_error); end
    endtask

    initial begin
        test_reset();
        test_relative();
        test_wrap();
        test_stall();
        test_length_error();
        test_reset_mid();
        test_rtnyes();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
